// File: rtl/mem_ctrl_if.sv
// Memory-side bus between the request arbiter and mem_ctrl.
// The arbiter is the master; mem_ctrl is the slave.
interface mem_ctrl_if;
    logic [63:0] addr_m;
    logic [63:0] dout_m;
    logic [63:0] din_m;
    logic        req_m;
    logic        wr_m;
    logic        rdy_m;
    logic        err_m;

    modport master (
        output addr_m,
        output dout_m,
        output req_m,
        output wr_m,
        input  din_m,
        input  rdy_m,
        input  err_m
    );

    modport slave (
        input  addr_m,
        input  dout_m,
        input  req_m,
        input  wr_m,
        output din_m,
        output rdy_m,
        output err_m
    );
endinterface

// File: rtl/mem_ctrl.sv
// Single-access memory slave with programmable read/write latency.
// A HOLD cycle after each completion swallows the arbiter's stale req.
module mem_ctrl #(
    parameter int AW_WORDS = 10,
    parameter int RD_LAT   = 2,
    parameter int WR_LAT   = 1
) (
    input  logic       clk,
    input  logic       reset,
    mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [3:0] RD_CNT = 4'(RD_LAT);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT);
    localparam int         DEPTH  = 2 ** AW_WORDS;

    state_t      state;
    state_t      state_n;
    logic [3:0]  cnt;
    logic [3:0]  cnt_n;
    logic        accept;
    logic        finish;

    logic [63:0] addr_q;
    logic [63:0] data_q;
    logic        wr_q;

    logic [63:0] din;
    logic        rdy;
    logic        err;

    logic [63:0] mem [DEPTH];

    logic [AW_WORDS-1:0] idx;
    logic                bad_addr;

    // Word index and error decode from the latched request address.
    assign idx      = addr_q[AW_WORDS+2:3];
    assign bad_addr = (|addr_q[2:0]) | (|addr_q[63:AW_WORDS+3]);

    assign bus.din_m = din;
    assign bus.rdy_m = rdy;
    assign bus.err_m = err;

    // Next-state logic: accept in IDLE, count down in BUSY, then DONE, HOLD.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_m) begin
                    accept  = 1'b1;
                    state_n = BUSY;
                    cnt_n   = bus.wr_m ? WR_CNT : RD_CNT;
                end
            end
            BUSY: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: state_n = HOLD;
            HOLD: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, counter, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            addr_q <= 64'd0;
            data_q <= 64'd0;
            wr_q   <= 1'b0;
            din    <= 64'd0;
            rdy    <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                addr_q <= bus.addr_m;
                data_q <= bus.dout_m;
                wr_q   <= bus.wr_m;
            end
            if (finish) begin
                rdy <= 1'b1;
                err <= bad_addr;
                if (!wr_q) begin
                    din <= bad_addr ? 64'd0 : mem[idx];
                end
            end else begin
                rdy <= 1'b0;
                err <= 1'b0;
            end
        end
    end

    // Array write on the edge entering DONE; blocked by reset or bad address.
    always_ff @(posedge clk) begin
        if (!reset && finish && wr_q && !bad_addr) begin
            mem[idx] <= data_q;
        end
    end

endmodule
